// File: rtl/paddle_quad_decoder.sv
// Filtered quadrature decoder: sync -> tick-sampled debounce -> Gray decode -> clamped paddle position.
// Latency: 2 cycles pin-to-sync, DEBOUNCE_LEN..DEBOUNCE_LEN+1 ticks to filtered, 1 cycle to outputs.
// Backpressure: none; free-running inputs. Optional QDEC_ERR_CNT_EN builds the illegal-transition counter.
module paddle_quad_decoder #(
   parameter int SAMPLE_DIV      = 1563,
   parameter int DEBOUNCE_LEN    = 4,
   parameter int COUNTS_PER_STEP = 4,
   parameter int POS_MAX         = 18,
   parameter int POS_RESET       = 9
) (
   input  logic       pxl_clk,
   input  logic       reset_n,
   input  logic       enc_a,
   input  logic       enc_b,
   input  logic       pos_load,
   output logic [5:0] position,
   output logic       step,
   output logic       dir,
   output logic [7:0] err_count
);

   localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [PW-1:0]     DIV_LAST     = PW'(SAMPLE_DIV - 1);
   localparam logic [5:0]        POS_TOP      = 6'(POS_MAX);
   localparam logic [5:0]        POS_INIT     = 6'(POS_RESET);
   localparam logic signed [3:0] ACC_INC_LAST = 4'(COUNTS_PER_STEP - 1);
   localparam logic signed [3:0] ACC_DEC_LAST = 4'(1 - COUNTS_PER_STEP);

   logic                    a_s1, a_s2, b_s1, b_s2;
   logic [PW-1:0]           pre_cnt;
   logic                    tick;
   logic [DEBOUNCE_LEN-1:0] win_a, win_b, win_a_nxt, win_b_nxt;
   logic [1:0]              filt_ab, prev_ab;
   logic                    edge_inc, edge_dec;
   logic signed [3:0]       acc, acc_nxt;
   logic                    inc_req, dec_req;

   always_ff @(posedge pxl_clk or negedge reset_n) begin
      if (!reset_n) begin
         a_s1 <= 1'b0;
         a_s2 <= 1'b0;
         b_s1 <= 1'b0;
         b_s2 <= 1'b0;
      end else begin
         a_s1 <= enc_a;
         a_s2 <= a_s1;
         b_s1 <= enc_b;
         b_s2 <= b_s1;
      end
   end

   assign tick = (pre_cnt == DIV_LAST);

   always_ff @(posedge pxl_clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign win_a_nxt = {win_a[DEBOUNCE_LEN-2:0], a_s2};
   assign win_b_nxt = {win_b[DEBOUNCE_LEN-2:0], b_s2};

   // A level is accepted only once the whole sample window agrees on it.
   always_ff @(posedge pxl_clk or negedge reset_n) begin
      if (!reset_n) begin
         win_a   <= '0;
         win_b   <= '0;
         filt_ab <= 2'b00;
      end else if (tick) begin
         win_a <= win_a_nxt;
         win_b <= win_b_nxt;
         if (&win_a_nxt)       filt_ab[1] <= 1'b1;
         else if (~|win_a_nxt) filt_ab[1] <= 1'b0;
         if (&win_b_nxt)       filt_ab[0] <= 1'b1;
         else if (~|win_b_nxt) filt_ab[0] <= 1'b0;
      end
   end

   always_ff @(posedge pxl_clk or negedge reset_n) begin
      if (!reset_n) prev_ab <= 2'b00;
      else          prev_ab <= filt_ab;
   end

   always_comb begin
      edge_inc = 1'b0;
      edge_dec = 1'b0;
      case ({prev_ab, filt_ab})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: edge_inc = 1'b1;
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: edge_dec = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      acc_nxt = acc;
      inc_req = 1'b0;
      dec_req = 1'b0;
      if (edge_inc) begin
         if (acc == ACC_INC_LAST) begin
            acc_nxt = '0;
            inc_req = 1'b1;
         end else begin
            acc_nxt = acc + 4'sd1;
         end
      end else if (edge_dec) begin
         if (acc == ACC_DEC_LAST) begin
            acc_nxt = '0;
            dec_req = 1'b1;
         end else begin
            acc_nxt = acc - 4'sd1;
         end
      end
   end

   // Requests past either end are dropped but still consume the detent.
   always_ff @(posedge pxl_clk or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= '0;
         position <= POS_INIT;
         step     <= 1'b0;
         dir      <= 1'b0;
      end else if (pos_load) begin
         acc      <= '0;
         position <= POS_INIT;
         step     <= 1'b0;
      end else begin
         acc  <= acc_nxt;
         step <= 1'b0;
         if (inc_req && (position != POS_TOP)) begin
            position <= position + 6'd1;
            step     <= 1'b1;
            dir      <= 1'b1;
         end else if (dec_req && (position != 6'd0)) begin
            position <= position - 6'd1;
            step     <= 1'b1;
            dir      <= 1'b0;
         end
      end
   end

`ifdef QDEC_ERR_CNT_EN
   logic illegal;
   assign illegal = &(prev_ab ^ filt_ab);

   always_ff @(posedge pxl_clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if (illegal && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_paddle_quad_decoder.sv
// Bench for paddle_quad_decoder: directed scenarios plus a random walk against a Gray-index model.
module tb_paddle_quad_decoder;

   localparam int SDIV = 4;
   localparam int DEB  = 4;
   localparam int CPS  = 4;
   localparam int PMAX = 18;
   localparam int PRST = 9;
   localparam int HOLD = DEB + 2;
`ifdef QDEC_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       pxl_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enc_a = 1'b0;
   logic       enc_b = 1'b0;
   logic       pos_load = 1'b0;
   logic [5:0] position;
   logic       step;
   logic       dir;
   logic [7:0] err_count;

   paddle_quad_decoder #(
      .SAMPLE_DIV(SDIV), .DEBOUNCE_LEN(DEB), .COUNTS_PER_STEP(CPS),
      .POS_MAX(PMAX), .POS_RESET(PRST)
   ) dut (
      .pxl_clk(pxl_clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
      .pos_load(pos_load), .position(position), .step(step), .dir(dir),
      .err_count(err_count)
   );

   always #5 pxl_clk = ~pxl_clk;

   int n_cmp = 0;
   int n_bad = 0;

   int   step_seen = 0;
   int   double_steps = 0;
   logic step_q = 1'b0;
   always @(negedge pxl_clk) begin
      if (step) step_seen++;
      if (step && step_q) double_steps++;
      step_q = step;
   end

   // Model state: Gray index of the filtered level (00,01,11,10 -> 0..3).
   int m_idx = 0, m_acc = 0, m_pos = PRST, m_steps = 0, m_err = 0;
   bit m_dir = 1'b0;

   function automatic logic [1:0] gray(input int i);
      case (i)
         0: return 2'b00;
         1: return 2'b01;
         2: return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic model_edge(input int new_idx);
      int d;
      d = (new_idx - m_idx + 4) % 4;
      m_idx = new_idx;
      if (d == 1) begin
         m_acc++;
         if (m_acc == CPS) begin
            m_acc = 0;
            if (m_pos < PMAX) begin m_pos++; m_steps++; m_dir = 1'b1; end
         end
      end else if (d == 3) begin
         m_acc--;
         if (m_acc == -CPS) begin
            m_acc = 0;
            if (m_pos > 0) begin m_pos--; m_steps++; m_dir = 1'b0; end
         end
      end else if (d == 2) begin
         if (m_err < 255) m_err++;
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_acc = 0; m_pos = PRST; m_err = 0; m_dir = 1'b0;
   endtask

   task automatic wait_ticks(input int t);
      repeat (t * SDIV) @(negedge pxl_clk);
   endtask

   task automatic move(input int dirn, input int hold);
      int ni;
      ni = (m_idx + ((dirn > 0) ? 1 : 3)) % 4;
      {enc_a, enc_b} = gray(ni);
      model_edge(ni);
      wait_ticks(hold);
   endtask

   task automatic pulse_load();
      @(negedge pxl_clk) pos_load = 1'b1;
      @(negedge pxl_clk) pos_load = 1'b0;
      m_pos = PRST;
      m_acc = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      {enc_a, enc_b} = 2'b00;
      model_reset();
      repeat (3) @(negedge pxl_clk);
      n_cmp++; if (position !== 6'(PRST)) begin n_bad++; $display("FAIL reset_position: got %0d want %0d", position, PRST); end
      n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL reset_step: got %b want 0", step); end
      n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir: got %b want 0", dir); end
      n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err_count); end
      reset_n = 1'b1;
      wait_ticks(2);
   endtask

   task automatic test_cw_cycles();
      int s0;
      s0 = step_seen;
      for (int i = 0; i < 4 * CPS; i++) move(1, HOLD);
      n_cmp++; if (position !== 6'(PRST + 4)) begin n_bad++; $display("FAIL cw_position: got %0d want %0d", position, PRST + 4); end
      n_cmp++; if (step_seen - s0 != 4) begin n_bad++; $display("FAIL cw_steps: got %0d want 4", step_seen - s0); end
      n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL cw_dir: got %b want 1", dir); end
   endtask

   task automatic test_reversal();
      int s0;
      pulse_load();
      s0 = step_seen;
      move(1, HOLD); move(1, HOLD); move(-1, HOLD); move(-1, HOLD);
      n_cmp++; if (position !== 6'(PRST)) begin n_bad++; $display("FAIL rev_position: got %0d want %0d", position, PRST); end
      n_cmp++; if (step_seen != s0) begin n_bad++; $display("FAIL rev_steps: got %0d want 0", step_seen - s0); end
      for (int i = 0; i < CPS - 1; i++) move(1, HOLD);
      n_cmp++; if (position !== 6'(PRST)) begin n_bad++; $display("FAIL rev_acc_partial: got %0d want %0d", position, PRST); end
      move(1, HOLD);
      n_cmp++; if (position !== 6'(PRST + 1)) begin n_bad++; $display("FAIL rev_acc_full: got %0d want %0d", position, PRST + 1); end
   endtask

   task automatic test_ccw_clamp();
      int s0, start;
      s0 = step_seen;
      start = m_pos;
      for (int i = 0; i < 40 * CPS; i++) move(-1, HOLD);
      n_cmp++; if (position !== 6'd0) begin n_bad++; $display("FAIL clamp_low_position: got %0d want 0", position); end
      n_cmp++; if (step_seen - s0 != start) begin n_bad++; $display("FAIL clamp_low_steps: got %0d want %0d", step_seen - s0, start); end
      n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL clamp_low_dir: got %b want 0", dir); end
      for (int i = 0; i < CPS; i++) move(1, HOLD);
      n_cmp++; if (position !== 6'd1) begin n_bad++; $display("FAIL clamp_recover: got %0d want 1", position); end
   endtask

   // Glitch A while three edges into a detent: an accepted glitch would complete the detent.
   task automatic test_glitch();
      int s0, p0;
      for (int i = 0; i < CPS - 1; i++) move(1, HOLD);
      s0 = step_seen;
      p0 = m_pos;
      enc_a = ~enc_a;
      repeat ((DEB - 1) * SDIV) @(negedge pxl_clk);
      enc_a = ~enc_a;
      wait_ticks(HOLD);
      n_cmp++; if (position !== 6'(p0)) begin n_bad++; $display("FAIL glitch_position: got %0d want %0d", position, p0); end
      n_cmp++; if (step_seen != s0) begin n_bad++; $display("FAIL glitch_steps: got %0d want 0", step_seen - s0); end
      n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL glitch_err: got %0d want 0", err_count); end
      move(1, HOLD);
      n_cmp++; if (position !== 6'(p0 + 1)) begin n_bad++; $display("FAIL glitch_then_edge: got %0d want %0d", position, p0 + 1); end
   endtask

   task automatic test_illegal();
      int s0, p0, exp_err;
      s0 = step_seen;
      p0 = m_pos;
      {enc_a, enc_b} = gray((m_idx + 2) % 4);
      model_edge((m_idx + 2) % 4);
      wait_ticks(HOLD);
      exp_err = ERR_EN ? m_err : 0;
      n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL illegal_err: got %0d want %0d", err_count, exp_err); end
      n_cmp++; if (position !== 6'(p0)) begin n_bad++; $display("FAIL illegal_position: got %0d want %0d", position, p0); end
      n_cmp++; if (step_seen != s0) begin n_bad++; $display("FAIL illegal_steps: got %0d want 0", step_seen - s0); end
   endtask

   task automatic test_load_same_cycle();
      int s0, ni;
      pulse_load();
      for (int i = 0; i < 6 * CPS; i++) move(1, HOLD);
      n_cmp++; if (position !== 6'(PRST + 6)) begin n_bad++; $display("FAIL load_setup: got %0d want %0d", position, PRST + 6); end
      for (int i = 0; i < CPS - 1; i++) move(1, HOLD);
      s0 = step_seen;
      ni = (m_idx + 1) % 4;
      @(negedge pxl_clk);
      {enc_a, enc_b} = gray(ni);
      pos_load = 1'b1;
      wait_ticks(HOLD);
      pos_load = 1'b0;
      m_idx = ni; m_acc = 0; m_pos = PRST;
      @(negedge pxl_clk);
      n_cmp++; if (position !== 6'(PRST)) begin n_bad++; $display("FAIL load_position: got %0d want %0d", position, PRST); end
      n_cmp++; if (step_seen != s0) begin n_bad++; $display("FAIL load_step: got %0d want 0", step_seen - s0); end
      n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL load_dir_kept: got %b want 1", dir); end
      for (int i = 0; i < CPS - 1; i++) move(1, HOLD);
      n_cmp++; if (position !== 6'(PRST)) begin n_bad++; $display("FAIL load_acc_cleared: got %0d want %0d", position, PRST); end
      move(1, HOLD);
      n_cmp++; if (position !== 6'(PRST + 1)) begin n_bad++; $display("FAIL load_next_detent: got %0d want %0d", position, PRST + 1); end
   endtask

   task automatic test_random_walk();
      int s0, m0, d, run, exp_err;
      s0 = step_seen;
      m0 = m_steps;
      for (int r = 0; r < 30; r++) begin
         d = ($urandom_range(1, 0) == 1) ? 1 : -1;
         run = $urandom_range(8, 1);
         for (int k = 0; k < run; k++) move(d, $urandom_range(DEB + 4, DEB + 2));
         if ($urandom_range(7, 0) == 0) pulse_load();
         @(negedge pxl_clk);
         n_cmp++; if (position !== 6'(m_pos)) begin n_bad++; $display("FAIL rand_position[%0d]: got %0d want %0d", r, position, m_pos); end
         n_cmp++; if (dir !== m_dir) begin n_bad++; $display("FAIL rand_dir[%0d]: got %b want %b", r, dir, m_dir); end
      end
      exp_err = ERR_EN ? m_err : 0;
      n_cmp++; if (step_seen - s0 != m_steps - m0) begin n_bad++; $display("FAIL rand_steps: got %0d want %0d", step_seen - s0, m_steps - m0); end
      n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL rand_err: got %0d want %0d", err_count, exp_err); end
   endtask

   task automatic test_reset_mid();
      pulse_load();
      for (int i = 0; i < CPS; i++) move(1, HOLD);
      move(1, HOLD); move(1, HOLD);
      {enc_a, enc_b} = gray((m_idx + 1) % 4);
      wait_ticks(DEB - 1);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (position !== 6'(PRST)) begin n_bad++; $display("FAIL rstmid_position: got %0d want %0d", position, PRST); end
      n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL rstmid_step: got %b want 0", step); end
      n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL rstmid_dir: got %b want 0", dir); end
      n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL rstmid_err: got %0d want 0", err_count); end
      {enc_a, enc_b} = 2'b00;
      model_reset();
      repeat (3) @(negedge pxl_clk);
      reset_n = 1'b1;
      for (int i = 0; i < CPS; i++) move(1, HOLD);
      n_cmp++; if (position !== 6'(PRST + 1)) begin n_bad++; $display("FAIL rstmid_restart: got %0d want %0d", position, PRST + 1); end
   endtask

   initial begin
      test_reset();
      test_cw_cycles();
      test_reversal();
      test_ccw_clamp();
      test_glitch();
      test_illegal();
      test_load_same_cycle();
      test_random_walk();
      test_reset_mid();
      n_cmp++; if (double_steps != 0) begin n_bad++; $display("FAIL step_consecutive: got %0d want 0", double_steps); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
